fsi_tx_arbiter: RTL
===================

Name: fsi_tx_arbiter

Overview:
Shares the FTDI fast opto-isolated serial transmit path (FSDI/FSCTS, FSCLK = clk at top level) between NREQ requesters, e.g. the logic-analyzer sampler and a status/ADC channel. Per-requester valid/ready handshake with round-robin arbitration. Gates frame start on FSCTS. Serializes each granted byte as start bit, 8 data bits LSB first, then the destination-port bit (1 = port B).

Parameters:
NREQ, 2, number of requesters (2..4)
GAP_CYCLES, 0, extra FSDI=1 idle cycles inserted after each frame, beyond the mandatory single idle cycle
IDW, 2, width of grant_id (>= clog2(NREQ), min 1)

Ports:
clk  in  1  system clock; also drives FSCLK at top level
rst_n  in  1  asynchronous active-low reset
req_valid  in  NREQ  request i has a byte pending; held until req_ready[i]
req_data  in  8*NREQ  byte i at [8i+7:8i]; stable while req_valid[i]
req_dest  in  NREQ  destination bit for request i (1 = port B, 0 = port A)
req_ready  out  NREQ  one-cycle accept pulse to the granted requester
fscts  in  1  FTDI clear-to-send, synchronous to clk
fsdi  out  1  serial data to FTDI, registered
busy  out  1  frame or gap in progress
grant_id  out  IDW  index of the most recently granted requester

Behaviour:
- Reset (async, rst_n=0): fsdi=1, busy=0, req_ready=0, grant_id=0, state IDLE, RR pointer=NREQ-1 (req 0 wins first), bit counter=0. A frame in flight is truncated immediately.
- States: IDLE -> START -> DATA (8 cycles) -> DEST -> GAP (GAP_CYCLES cycles, skipped if 0) -> IDLE.
- IDLE: fsdi=1, busy=0. Arbitration is evaluated only here.
- A grant occurs in cycle T if fscts=1 and any req_valid=1. If fscts=0, there is no grant and req_ready stays 0.
- Arbitration: the winner is the lowest index strictly after the RR pointer, circular. The pointer updates to the winner on grant.
- On a grant in T: latch req_data/req_dest of the winner into the shift register, and update grant_id.
- Cycle T+1: req_ready[winner]=1 for exactly this cycle; fsdi=0 (start bit); busy=1.
- Cycles T+2..T+9: fsdi = data[0]..data[7].
- Cycle T+10: fsdi = dest bit.
- Then fsdi=1 for GAP_CYCLES cycles with busy=1, then IDLE (fsdi=1, busy=0).
- Frame period: 11+GAP_CYCLES cycles with back-to-back requests. The minimum is one fsdi=1 cycle between frames.
- fscts changes after START are ignored; the frame always completes.
- req_valid deasserting before its grant is legal; that request is simply skipped.
- Valid bits of ungranted requesters are preserved; they are not acknowledged.
- Only one req_ready bit is ever high, and only in START.
- Multiple simultaneous valids resolve by round-robin only. There is no fixed priority except immediately after reset.
- Requests arriving during busy wait for IDLE. There is no internal buffering beyond the single shift register.

Optional Feature:
FSI_TX_FRAME_CNT_EN
- Defined: adds output frame_count [15:0]. Resets to 0, increments by 1 in each DEST cycle, and wraps 0xFFFF -> 0x0000.
- Undefined: the port and counter are absent. All other behaviour is identical.

Test Plan:
- Single frame: reset, req_valid=01, req_data[7:0]=0xA5, req_dest[0]=1, fscts=1 at cycle 0 -> req_ready=01 at cycle 1; fsdi cycles 1..10 = 0,1,0,1,0,0,1,0,1,1; fsdi=1 and busy=0 at cycle 11.
- CTS gating: req_valid=01, fscts=0 for 20 cycles -> fsdi=1, req_ready=0 throughout. Raise fscts -> start bit on the next cycle.
- Round-robin: req_valid=11 held continuously, data 0x11/0x22, fscts=1 -> grant order 0,1,0,1. req_ready pulses 11 cycles apart; grant_id alternates.
- CTS drop mid-frame: deassert fscts at data bit 3 -> the frame completes unchanged, and the next grant waits for fscts=1.
- Async reset mid-frame: rst_n=0 at data bit 5 -> fsdi=1 and busy=0 without a clock edge. After release, req 0 wins first even if req 1 was last granted.
- GAP_CYCLES=3 with continuous req 0 -> frames start every 14 cycles. With FSI_TX_FRAME_CNT_EN, frame_count reaches 4 after 4 frames, and wraps 0xFFFF -> 0 when preloaded by forcing.

Source files
------------

// File: rtl/fsi_tx_arbiter.sv
// fsi_tx_arbiter: round-robin arbiter and serializer for the FTDI fast serial transmit path (optional FSI_TX_FRAME_CNT_EN adds frame_count_o)
module fsi_tx_arbiter #(
   parameter int NREQ       = 2,
   parameter int GAP_CYCLES = 0,
   parameter int IDW        = 2
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic [NREQ-1:0]   req_valid_i,
   input  logic [8*NREQ-1:0] req_data_i,
   input  logic [NREQ-1:0]   req_dest_i,
   output logic [NREQ-1:0]   req_ready_o,
   input  logic              fscts_i,
   output logic              fsdi_o,
   output logic              busy_o,
`ifdef FSI_TX_FRAME_CNT_EN
   output logic [IDW-1:0]    grant_id_o,
   output logic [15:0]       frame_count_o
`else
   output logic [IDW-1:0]    grant_id_o
`endif
);
   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_DEST, S_GAP} state_t;
   localparam logic [15:0] GAP_LAST = 16'(GAP_CYCLES > 0 ? GAP_CYCLES - 1 : 0);
   state_t state_q, state_d;
   logic [15:0] cnt_q, cnt_d;
   logic [8:0] sh_q, sh_d;
   logic fsdi_q, fsdi_d;
   logic [NREQ-1:0] rdy_q, rdy_d;
   logic [IDW-1:0] ptr_q, ptr_d, gid_q, gid_d;
   logic found_hi, found_lo;
   logic [IDW-1:0] win_hi, win_lo, win;
   logic [7:0] sel_data;
   logic sel_dest;
   logic [NREQ-1:0] win_oh;
   // round-robin pick: lowest valid index above the pointer, else lowest at or below it
   always_comb begin
      found_hi = 1'b0;
      found_lo = 1'b0;
      win_hi = '0;
      win_lo = '0;
      for (int i = NREQ - 1; i >= 0; i--) begin
         if (req_valid_i[i] && i > int'(ptr_q)) begin
            found_hi = 1'b1;
            win_hi = IDW'(i);
         end
         if (req_valid_i[i] && i <= int'(ptr_q)) begin
            found_lo = 1'b1;
            win_lo = IDW'(i);
         end
      end
      win = found_hi ? win_hi : win_lo;
      sel_data = '0;
      sel_dest = 1'b0;
      win_oh = '0;
      for (int i = 0; i < NREQ; i++) begin
         win_oh[i] = (IDW'(i) == win);
         if (IDW'(i) == win) begin
            sel_data = req_data_i[8*i +: 8];
            sel_dest = req_dest_i[i];
         end
      end
   end
   // frame sequencer: grant in idle, then start, 8 data bits, dest bit, optional gap
   always_comb begin
      state_d = state_q;
      cnt_d = cnt_q;
      sh_d = sh_q;
      fsdi_d = 1'b1;
      rdy_d = '0;
      ptr_d = ptr_q;
      gid_d = gid_q;
      case (state_q)
         S_IDLE: if (fscts_i && (found_hi || found_lo)) begin
            state_d = S_START;
            sh_d = {sel_dest, sel_data};
            ptr_d = win;
            gid_d = win;
            rdy_d = win_oh;
            fsdi_d = 1'b0;
         end
         S_START: begin
            state_d = S_DATA;
            cnt_d = '0;
            fsdi_d = sh_q[0];
            sh_d = sh_q >> 1;
         end
         S_DATA: begin
            fsdi_d = sh_q[0];
            sh_d = sh_q >> 1;
            cnt_d = (cnt_q == 16'd7) ? '0 : cnt_q + 16'd1;
            state_d = (cnt_q == 16'd7) ? S_DEST : S_DATA;
         end
         S_DEST: begin
            cnt_d = '0;
            state_d = (GAP_CYCLES > 0) ? S_GAP : S_IDLE;
         end
         S_GAP: begin
            cnt_d = (cnt_q == GAP_LAST) ? '0 : cnt_q + 16'd1;
            state_d = (cnt_q == GAP_LAST) ? S_IDLE : S_GAP;
         end
         default: state_d = S_IDLE;
      endcase
   end
   // state and datapath registers; reset truncates any frame in flight
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= S_IDLE;
         cnt_q <= '0;
         sh_q <= '0;
         fsdi_q <= 1'b1;
         rdy_q <= '0;
         ptr_q <= IDW'(NREQ - 1);
         gid_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q <= cnt_d;
         sh_q <= sh_d;
         fsdi_q <= fsdi_d;
         rdy_q <= rdy_d;
         ptr_q <= ptr_d;
         gid_q <= gid_d;
      end
   end
`ifdef FSI_TX_FRAME_CNT_EN
   logic [15:0] fc_q;
   // count completed frames, bumping at the end of each dest-bit cycle
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) fc_q <= '0;
      else if (state_q == S_DEST) fc_q <= fc_q + 16'd1;
   end
   assign frame_count_o = fc_q;
`endif
   assign req_ready_o = rdy_q;
   assign fsdi_o = fsdi_q;
   assign busy_o = (state_q != S_IDLE);
   assign grant_id_o = gid_q;
endmodule
